// File: rtl/qam16_pkg.sv
// -----------------------------------------------------------------------------
// qam16_pkg
// Constants shared by the 16-QAM mapper and demapper:
//   - Gray codes for one 2-bit constellation field (I or Q axis)
//   - FSM state encoding of the mapper
//   - symbol sample width
// -----------------------------------------------------------------------------
package qam16_pkg;

  // Width of one signed I or Q sample.
  localparam int SYM_W = 8;

  // Gray-coded 2-bit field -> constellation level. Neighbouring levels
  // differ in one bit, so a one-level slicer error costs a single bit.
  localparam logic [1:0] GRAY_NEG3 = 2'b00;
  localparam logic [1:0] GRAY_NEG1 = 2'b01;
  localparam logic [1:0] GRAY_POS1 = 2'b11;
  localparam logic [1:0] GRAY_POS3 = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/qam16_mapper_if.sv
// -----------------------------------------------------------------------------
// qam16_mapper_if
// Bus between the nibble source / symbol sink and the mapper.
//
// Handshake: there is no ready. A nibble is taken on every rising sclk edge
// where write=1 and full=0; a write while full=1 is dropped and sets the
// sticky overflow flag. On the output side valid=1 marks I_out/Q_out as a
// data symbol; the sink samples them once per symbol period and cannot
// stall the mapper.
//
// Signals:
//   enable      source -> mapper  symbol divider run / freeze
//   data_in[4]  source -> mapper  nibble, [3:2] = I field, [1:0] = Q field
//   write       source -> mapper  push data_in
//   full        mapper -> source  FIFO full
//   overflow    mapper -> source  sticky dropped-write flag
//   I_out/Q_out mapper -> sink    signed levels
//   valid       mapper -> sink    I_out/Q_out carry a data symbol
//   busy        mapper -> sink    FSM in RUN
//   complete    mapper -> sink    one-cycle end-of-burst pulse
//   dbg_state   mapper -> observer FSM state
//   dbg_div     mapper -> observer symbol divider value (zero-extended)
// -----------------------------------------------------------------------------
interface qam16_mapper_if;
  import qam16_pkg::*;

  logic             enable;
  logic [3:0]       data_in;
  logic             write;
  logic             full;
  logic             overflow;
  logic [SYM_W-1:0] I_out;
  logic [SYM_W-1:0] Q_out;
  logic             valid;
  logic             busy;
  logic             complete;
  state_e           dbg_state;
  logic [7:0]       dbg_div;

  modport master (
    output enable, data_in, write,
    input  full, overflow, I_out, Q_out, valid, busy, complete,
           dbg_state, dbg_div
  );

  modport slave (
    input  enable, data_in, write,
    output full, overflow, I_out, Q_out, valid, busy, complete,
           dbg_state, dbg_div
  );

endinterface

// File: rtl/qam16_sym_fifo.sv
// -----------------------------------------------------------------------------
// qam16_sym_fifo
// Synchronous nibble FIFO with occupancy count. Read data is the current
// head entry (show-ahead); a pop advances to the next entry. A push into an
// empty FIFO becomes visible only on the following cycle.
//
// Ports:
//   sclk, reset_n      clock, async active-low reset
//   push_i, wr_data_i  write request and data (ignored while full)
//   pop_i              read request (ignored while empty)
//   rd_data_o          head entry
//   count_o            occupancy, 0..DEPTH
//   full_o, empty_o    occupancy flags
// -----------------------------------------------------------------------------
module qam16_sym_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     sclk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [3:0]               wr_data_i,
  input  logic                     pop_i,
  output logic [3:0]               rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [3:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign push_ok   = push_i && !full_o;
  assign pop_ok    = pop_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge sclk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/qam16_mapper.sv
// -----------------------------------------------------------------------------
// qam16_mapper
// 16-QAM transmit mapper. Nibbles are buffered in a FIFO; once START_LEVEL
// nibbles are queued, one nibble per symbol period is turned into a
// Gray-coded signed I/Q pair. The burst ends when the FIFO is found empty
// at a symbol tick, which pulses complete for one cycle.
//
// Ports:
//   sclk     system clock, rising edge
//   reset_n  async active-low reset
//   bus      qam16_mapper_if.slave (data in, flags, I/Q out, debug)
//
// Parameters:
//   DEPTH        FIFO depth in nibbles (power of 2, >= 4)
//   SYM_DIV      clock cycles per symbol period (2..256)
//   AMP          inner level; outer level is 3*AMP (3*AMP <= 127)
//   START_LEVEL  FIFO occupancy needed to start a burst (1..DEPTH)
// -----------------------------------------------------------------------------
module qam16_mapper
  import qam16_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int SYM_DIV     = 4,
  parameter int AMP         = 32,
  parameter int START_LEVEL = 4
) (
  input  logic           sclk,
  input  logic           reset_n,
  qam16_mapper_if.slave  bus
);

  localparam int DIV_W = $clog2(SYM_DIV);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [SYM_W-1:0] LVL_NEG3 = SYM_W'(-3 * AMP);
  localparam logic [SYM_W-1:0] LVL_NEG1 = SYM_W'(-AMP);
  localparam logic [SYM_W-1:0] LVL_POS1 = SYM_W'(AMP);
  localparam logic [SYM_W-1:0] LVL_POS3 = SYM_W'(3 * AMP);

  function automatic logic [SYM_W-1:0] gray_level(input logic [1:0] code);
    logic [SYM_W-1:0] lvl;
    lvl = '0;
    case (code)
      GRAY_NEG3: lvl = LVL_NEG3;
      GRAY_NEG1: lvl = LVL_NEG1;
      GRAY_POS1: lvl = LVL_POS1;
      GRAY_POS3: lvl = LVL_POS3;
      default:   lvl = '0;
    endcase
    return lvl;
  endfunction

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             tick;
  logic             push;
  logic             pop;
  logic [3:0]       head;
  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             fifo_empty;

  state_e           state_q;
  logic [SYM_W-1:0] i_q;
  logic [SYM_W-1:0] q_q;
  logic             valid_q;
  logic             complete_q;
  logic             overflow_q;

  assign tick  = bus.enable && (div_q == DIV_W'(SYM_DIV - 1));
  assign div_d = tick ? '0 : div_q + DIV_W'(1);
  assign push  = bus.write && !fifo_full;

  // Pop decisions use the registered count, so a nibble written this cycle
  // cannot be popped in the same cycle.
  always_comb begin
    pop = 1'b0;
    if (tick) begin
      if (state_q == ST_IDLE) pop = (count >= CNT_W'(START_LEVEL));
      else                    pop = !fifo_empty;
    end
  end

  qam16_sym_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .sclk      (sclk),
    .reset_n   (reset_n),
    .push_i    (push),
    .wr_data_i (bus.data_in),
    .pop_i     (pop),
    .rd_data_o (head),
    .count_o   (count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
    end else if (bus.enable) begin
      div_q <= div_d;
    end
  end

  // Full is checked before this cycle's pop, so a write racing a pop on a
  // full FIFO is still dropped.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else if (bus.write && fifo_full) begin
      overflow_q <= 1'b1;
    end
  end

  // FSM with registered symbol outputs. Outputs change only on a tick, so
  // enable=0 freezes them; complete is a pulse and always self-clears.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      i_q        <= '0;
      q_q        <= '0;
      valid_q    <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      complete_q <= 1'b0;
      if (tick) begin
        if (pop) begin
          state_q <= ST_RUN;
          i_q     <= gray_level(head[3:2]);
          q_q     <= gray_level(head[1:0]);
          valid_q <= 1'b1;
        end else begin
          i_q     <= '0;
          q_q     <= '0;
          valid_q <= 1'b0;
          if (state_q == ST_RUN) begin
            state_q    <= ST_IDLE;
            complete_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.full      = fifo_full;
  assign bus.overflow  = overflow_q;
  assign bus.I_out     = i_q;
  assign bus.Q_out     = q_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.complete  = complete_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_div   = 8'(div_q);

endmodule

// File: tb/tb_qam16_mapper.sv
// -----------------------------------------------------------------------------
// tb_qam16_mapper
// Directed bench for qam16_mapper with default parameters
// (DEPTH=16, SYM_DIV=4, AMP=32, START_LEVEL=4). All inputs change on the
// falling edge; all outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_qam16_mapper;
  import qam16_pkg::*;

  localparam int SYM_DIV = 4;

  logic sclk = 1'b0;
  logic reset_n = 1'b0;

  qam16_mapper_if bus ();

  qam16_mapper #(
    .DEPTH       (16),
    .SYM_DIV     (SYM_DIV),
    .AMP         (32),
    .START_LEVEL (4)
  ) dut (
    .sclk    (sclk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock ----------------
  always #5 sclk = ~sclk;

  // ---------------- scoreboard ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] exp_q[$];

  // Level by 2-bit code: 00=-96, 01=-32, 10=+96, 11=+32.
  logic [7:0] lvl_tab [4] = '{8'hA0, 8'hE0, 8'h60, 8'h20};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Demapper-style slicer used for the loopback check.
  function automatic logic [1:0] slice(input logic signed [7:0] v);
    if (v >= 64)       return 2'b10;
    else if (v >= 0)   return 2'b11;
    else if (v >= -64) return 2'b01;
    else               return 2'b00;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge sclk);
  endtask

  // Called at a falling edge; returns one falling edge later.
  task automatic push_nibble(input logic [3:0] n);
    bus.data_in = n;
    bus.write   = 1'b1;
    @(negedge sclk);
    bus.write   = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int waited);
    waited = 0;
    while (!bus.valid && waited < budget) begin
      step(1);
      waited++;
    end
  endtask

  task automatic chk_sym(input string tag, input logic [3:0] n);
    logic [1:0] fi;
    logic [1:0] fq;
    fi = n[3:2];
    fq = n[1:0];
    chk({tag, "_I"}, bus.I_out, lvl_tab[fi]);
    chk({tag, "_Q"}, bus.Q_out, lvl_tab[fq]);
    chk({tag, "_valid"}, bus.valid, 1'b1);
  endtask

  // Called at the first falling edge after the last symbol's final tick.
  task automatic end_burst(input string tag);
    chk({tag, "_end_valid"}, bus.valid, 1'b0);
    chk({tag, "_end_I"}, bus.I_out, 8'h00);
    chk({tag, "_end_complete"}, bus.complete, 1'b1);
    chk({tag, "_end_busy"}, bus.busy, 1'b0);
    step(1);
    chk({tag, "_complete_1cyc"}, bus.complete, 1'b0);
  endtask

  task automatic run_burst(input string tag, input int n_sym);
    logic [3:0] n;
    for (int k = 0; k < n_sym; k++) begin
      n = exp_q.pop_front();
      chk_sym($sformatf("%s_sym%0d", tag, k), n);
      chk($sformatf("%s_busy%0d", tag, k), bus.busy, 1'b1);
      step(SYM_DIV);
    end
    end_burst(tag);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int         w;
    logic [3:0] n;
    logic [3:0] got;

    bus.enable  = 1'b0;
    bus.data_in = 4'h0;
    bus.write   = 1'b0;
    step(2);

    // Reset state
    chk("rst_I", bus.I_out, 8'h00);
    chk("rst_Q", bus.Q_out, 8'h00);
    chk("rst_valid", bus.valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_complete", bus.complete, 1'b0);
    chk("rst_full", bus.full, 1'b0);
    chk("rst_overflow", bus.overflow, 1'b0);
    reset_n = 1'b1;
    bus.enable = 1'b1;
    step(1);

    // T1: nibbles 0..F written back-to-back while running
    for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
    fork
      begin
        for (int i = 0; i < 16; i++) push_nibble(4'(i));
      end
      begin
        wait_valid(3 * SYM_DIV, w);
        chk("t1_first_valid", bus.valid, 1'b1);
        run_burst("t1", 16);
      end
    join
    step(3);

    // T2: below START_LEVEL nothing is emitted
    push_nibble(4'h3);
    push_nibble(4'hC);
    push_nibble(4'h9);
    for (int i = 0; i < 16; i++) begin
      step(1);
      chk("t2_idle_valid", bus.valid, 1'b0);
    end
    chk("t2_idle_busy", bus.busy, 1'b0);
    exp_q = '{4'h3, 4'hC, 4'h9, 4'hE};
    push_nibble(4'hE);
    wait_valid(SYM_DIV, w);
    chk("t2_first_valid", bus.valid, 1'b1);
    chk("t2_latency_range", 8'((w >= 1) && (w <= SYM_DIV)), 8'h01);
    run_burst("t2", 4);
    step(2);

    // T3: fill while frozen, overflow on the 17th write
    bus.enable = 1'b0;
    step(1);
    for (int k = 0; k < 17; k++) begin
      n = (k < 16) ? 4'(15 - k) : 4'h7;
      push_nibble(n);
      if (k < 16) exp_q.push_back(n);
      if (k == 15) begin
        chk("t3_full_at16", bus.full, 1'b1);
        chk("t3_no_overflow_at16", bus.overflow, 1'b0);
      end
    end
    chk("t3_full_after17", bus.full, 1'b1);
    chk("t3_overflow_set", bus.overflow, 1'b1);
    step(5);
    chk("t3_frozen_no_valid", bus.valid, 1'b0);

    // T3/T4: drain 16 symbols, freezing for 10 cycles inside symbol 5
    bus.enable = 1'b1;
    wait_valid(2 * SYM_DIV, w);
    chk("t3_first_valid", bus.valid, 1'b1);
    for (int k = 0; k < 16; k++) begin
      n = exp_q.pop_front();
      chk_sym($sformatf("t3_sym%0d", k), n);
      if (k == 5) begin
        step(1);
        chk("t4_div_before", bus.dbg_div, 8'd1);
        bus.enable = 1'b0;
        for (int j = 0; j < 10; j++) begin
          step(1);
          chk_sym($sformatf("t4_frozen%0d", j), n);
          chk($sformatf("t4_div_frozen%0d", j), bus.dbg_div, 8'd1);
        end
        bus.enable = 1'b1;
        step(1);
        chk_sym("t4_resume_a", n);
        step(1);
        chk_sym("t4_resume_b", n);
        chk("t4_div_resume", bus.dbg_div, 8'd3);
        step(1);
      end else begin
        step(SYM_DIV);
      end
    end
    end_burst("t3");
    chk("t3_overflow_sticky", bus.overflow, 1'b1);
    chk("t3_full_cleared", bus.full, 1'b0);

    // T5: loopback through a slicer with random nibbles
    for (int b = 0; b < 6; b++) begin
      bus.enable = 1'b0;
      step(1);
      for (int i = 0; i < 16; i++) begin
        n = 4'($urandom_range(0, 15));
        exp_q.push_back(n);
        push_nibble(n);
      end
      bus.enable = 1'b1;
      wait_valid(2 * SYM_DIV, w);
      chk($sformatf("t5_b%0d_first_valid", b), bus.valid, 1'b1);
      for (int i = 0; i < 16; i++) begin
        got = {slice(bus.I_out), slice(bus.Q_out)};
        chk($sformatf("t5_b%0d_nib%0d", b, i), got, exp_q.pop_front());
        step(SYM_DIV);
      end
      end_burst($sformatf("t5_b%0d", b));
    end

    // T6: reset pulse mid-burst
    bus.enable = 1'b0;
    step(1);
    for (int i = 0; i < 8; i++) begin
      n = 4'(i * 3 + 1);
      exp_q.push_back(n);
      push_nibble(n);
    end
    bus.enable = 1'b1;
    wait_valid(2 * SYM_DIV, w);
    chk_sym("t6_sym0", exp_q.pop_front());
    step(SYM_DIV);
    chk_sym("t6_sym1", exp_q.pop_front());
    step(1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_I", bus.I_out, 8'h00);
    chk("t6_rst_Q", bus.Q_out, 8'h00);
    chk("t6_rst_valid", bus.valid, 1'b0);
    chk("t6_rst_busy", bus.busy, 1'b0);
    chk("t6_rst_overflow", bus.overflow, 1'b0);
    exp_q.delete();
    step(1);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("t6_post_valid", bus.valid, 1'b0);
      chk("t6_post_complete", bus.complete, 1'b0);
    end
    chk("t6_post_state", 8'(bus.dbg_state), 8'(ST_IDLE));
    exp_q = '{4'h5, 4'hA, 4'h0, 4'hF};
    push_nibble(4'h5);
    push_nibble(4'hA);
    push_nibble(4'h0);
    push_nibble(4'hF);
    wait_valid(SYM_DIV, w);
    chk("t6_new_first_valid", bus.valid, 1'b1);
    run_burst("t6", 4);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
